// File: rtl/ble_rx_framer_pkg.sv
// rtl/ble_rx_framer_pkg.sv - shared state encodings, error codes and default SOF for the BLE RX framer
package ble_rx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

endpackage

// File: rtl/ble_rx_framer_buf.sv
// rtl/ble_rx_framer_buf.sv - MAX_LEN x 8 payload buffer, synchronous write, asynchronous read
module ble_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [7:0]    data_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/ble_rx_framer.sv
// rtl/ble_rx_framer.sv - SOF/LEN/payload/XOR-checksum framer with gated payload release.
// Optional saturating frame counters when BLE_RX_STATS_EN is defined.
module ble_rx_framer
  import ble_rx_framer_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
  parameter int         TIMEOUT_CLKS = 26040
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Cmd_Valid,
  output logic [7:0]  o_Cmd_Byte,
  output logic        o_Cmd_Last,
  input  logic        i_Cmd_Ready,
  output logic        o_Frame_Ok,
  output logic        o_Frame_Err,
  output logic [1:0]  o_Err_Code,
  output logic        o_Overrun,
  output logic        o_Busy
`ifdef BLE_RX_STATS_EN
  ,
  output logic [15:0] o_Ok_Count,
  output logic [15:0] o_Err_Count
`endif
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CLKS);

  state_t         state_q, state_d;
  logic [IW-1:0]  len_q, len_d;
  logic [IW-1:0]  wr_idx_q, wr_idx_d;
  logic [IW-1:0]  rd_idx_q, rd_idx_d;
  logic [7:0]     csum_q, csum_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic [7:0]     cmd_byte_q, cmd_byte_d;
  logic           cmd_last_q, cmd_last_d;
  logic           ok_q, ok_d;
  logic           err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           ovr_q, ovr_d;
  logic           busy_q, busy_d;

  logic           buf_we;
  logic [AW-1:0]  rd_addr;
  logic [7:0]     rd_data;
  logic           in_frame;
  logic           tmo_hit;

  // Read address looks one entry ahead so the next byte is ready to register on a handshake.
  assign rd_addr  = (state_q == ST_DRAIN) ? AW'(rd_idx_q + IW'(1)) : '0;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CLKS - 2));

  ble_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk_i     (i_Clock),
    .we_i      (buf_we),
    .wr_idx_i  (wr_idx_q[AW-1:0]),
    .data_i    (i_Rx_Byte),
    .rd_idx_i  (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    csum_d      = csum_q;
    tmo_d       = (in_frame && !i_Rx_DV) ? tmo_q + TW'(1) : '0;
    cmd_valid_d = cmd_valid_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_last_d  = cmd_last_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    err_code_d  = ERR_NONE;
    ovr_d       = 1'b0;
    buf_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV && i_Rx_Byte == SOF_BYTE) begin
          state_d = ST_LEN;
          csum_d  = '0;
        end
      end
      ST_LEN: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == 8'd0 || int'(i_Rx_Byte) > MAX_LEN) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d    = IW'(i_Rx_Byte);
            csum_d   = i_Rx_Byte;
            wr_idx_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_Rx_DV) begin
          buf_we   = 1'b1;
          csum_d   = csum_q ^ i_Rx_Byte;
          wr_idx_d = wr_idx_q + IW'(1);
          if (wr_idx_q == len_q - IW'(1)) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == csum_q) begin
            state_d     = ST_DRAIN;
            ok_d        = 1'b1;
            rd_idx_d    = '0;
            cmd_valid_d = 1'b1;
            cmd_byte_d  = rd_data;
            cmd_last_d  = (len_q == IW'(1));
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        ovr_d = i_Rx_DV;
        if (cmd_valid_q && i_Cmd_Ready) begin
          if (cmd_last_q) begin
            state_d     = ST_IDLE;
            cmd_valid_d = 1'b0;
            cmd_byte_d  = '0;
            cmd_last_d  = 1'b0;
          end else begin
            rd_idx_d   = rd_idx_q + IW'(1);
            cmd_byte_d = rd_data;
            cmd_last_d = (rd_idx_q + IW'(2) == len_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe on the terminal count is handled above and wins over the timeout.
    if (in_frame && !i_Rx_DV && tmo_hit) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      cmd_last_q  <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_last_q  <= cmd_last_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign o_Cmd_Valid = cmd_valid_q;
  assign o_Cmd_Byte  = cmd_byte_q;
  assign o_Cmd_Last  = cmd_last_q;
  assign o_Frame_Ok  = ok_q;
  assign o_Frame_Err = err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Overrun   = ovr_q;
  assign o_Busy      = busy_q;

`ifdef BLE_RX_STATS_EN
  logic [15:0] ok_cnt_q, err_cnt_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (ok_d && ok_cnt_q != 16'hFFFF) begin
        ok_cnt_q <= ok_cnt_q + 16'd1;
      end
      if (err_d && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign o_Ok_Count  = ok_cnt_q;
  assign o_Err_Count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ble_rx_framer.sv
// tb/tb_ble_rx_framer.sv - table-driven and scoreboard bench for ble_rx_framer
module tb_ble_rx_framer;

  localparam int MAXL = 16;
  localparam int TMO  = 100;

  logic       i_Clock;
  logic       i_Reset;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Cmd_Valid;
  logic [7:0] o_Cmd_Byte;
  logic       o_Cmd_Last;
  logic       i_Cmd_Ready;
  logic       o_Frame_Ok;
  logic       o_Frame_Err;
  logic [1:0] o_Err_Code;
  logic       o_Overrun;
  logic       o_Busy;
`ifdef BLE_RX_STATS_EN
  logic [15:0] o_Ok_Count;
  logic [15:0] o_Err_Count;
`endif

  ble_rx_framer #(.MAX_LEN(MAXL), .SOF_BYTE(8'hAA), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .o_Cmd_Valid (o_Cmd_Valid),
    .o_Cmd_Byte  (o_Cmd_Byte),
    .o_Cmd_Last  (o_Cmd_Last),
    .i_Cmd_Ready (i_Cmd_Ready),
    .o_Frame_Ok  (o_Frame_Ok),
    .o_Frame_Err (o_Frame_Err),
    .o_Err_Code  (o_Err_Code),
    .o_Overrun   (o_Overrun),
    .o_Busy      (o_Busy)
`ifdef BLE_RX_STATS_EN
    ,
    .o_Ok_Count  (o_Ok_Count),
    .o_Err_Count (o_Err_Count)
`endif
  );

  typedef struct packed {
    logic [7:0]        len;
    logic [15:0][7:0]  pl;
    logic              bad;
    logic              exp_ok;
    logic [1:0]        exp_code;
  } vec_t;

  int checks = 0;
  int passed = 0;

  logic [8:0] dq[$];
  logic [2:0] evq[$];

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      if (dq.size() == 0 && evq.size() == 0 && !o_Busy) break;
      tick();
    end
    chk("drain_queue", dq.size(), 0);
    chk("event_queue", evq.size(), 0);
    chk("busy_idle", o_Busy, 0);
  endtask

  function automatic vec_t mk(input logic [7:0] len, input logic [7:0] seed, input logic bad,
                              input logic ok, input logic [1:0] code);
    vec_t v;
    v.len = len;
    for (int i = 0; i < 16; i++) v.pl[i] = seed + 8'(i * 37);
    v.bad      = bad;
    v.exp_ok   = ok;
    v.exp_code = code;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [7:0] cs;
    if (v.exp_ok) begin
      for (int i = 0; i < int'(v.len); i++) dq.push_back({(i == int'(v.len) - 1), v.pl[i]});
    end
    evq.push_back({v.exp_ok, v.exp_code});
    send(8'hAA);
    send(v.len);
    if (v.len != 0 && int'(v.len) <= MAXL) begin
      cs = v.len;
      for (int i = 0; i < int'(v.len); i++) begin
        send(v.pl[i]);
        cs = cs ^ v.pl[i];
      end
      send(v.bad ? (cs ^ 8'h5A) : cs);
    end
    wait_drain();
  endtask

  // Scoreboard: payload handshakes and frame result pulses are popped as they happen.
  always @(negedge i_Clock) begin : mon
    logic [8:0] de;
    logic [2:0] ee;
    if (!i_Reset) begin
      if (o_Cmd_Valid && i_Cmd_Ready) begin
        if (dq.size() == 0) chk("unexpected_byte", {24'd0, o_Cmd_Byte}, 32'hFFFF);
        else begin
          de = dq.pop_front();
          chk("cmd_byte", o_Cmd_Byte, de[7:0]);
          chk("cmd_last", o_Cmd_Last, de[8]);
        end
      end
      if (o_Frame_Ok || o_Frame_Err) begin
        if (evq.size() == 0) chk("unexpected_result", {o_Frame_Ok, o_Frame_Err}, 0);
        else begin
          ee = evq.pop_front();
          chk("frame_ok", o_Frame_Ok, ee[2]);
          chk("frame_err", o_Frame_Err, !ee[2]);
          chk("err_code", o_Err_Code, ee[1:0]);
        end
      end else begin
        chk("err_code_quiet", o_Err_Code, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(8'd3,  8'h00, 1'b0, 1'b1, 2'd0);
    vecs[0].pl[0] = 8'h11; vecs[0].pl[1] = 8'h22; vecs[0].pl[2] = 8'h33;
    vecs[1] = mk(8'd2,  8'h10, 1'b1, 1'b0, 2'd2);
    vecs[2] = mk(8'd0,  8'h00, 1'b0, 1'b0, 2'd1);
    vecs[3] = mk(8'h11, 8'h00, 1'b0, 1'b0, 2'd1);
    vecs[4] = mk(8'd3,  8'h40, 1'b0, 1'b1, 2'd0);
    vecs[5] = mk(8'd1,  8'h5A, 1'b0, 1'b1, 2'd0);
    vecs[6] = mk(8'd16, 8'h07, 1'b0, 1'b1, 2'd0);
    vecs[7] = mk(8'd16, 8'h99, 1'b1, 1'b0, 2'd2);
    vecs[8] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 2'd1);

    i_Reset = 1'b1; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_Cmd_Ready = 1'b1;
    tick(); tick();
    chk("rst_valid", o_Cmd_Valid, 0);
    chk("rst_byte", o_Cmd_Byte, 0);
    chk("rst_last", o_Cmd_Last, 0);
    chk("rst_ok", o_Frame_Ok, 0);
    chk("rst_err", o_Frame_Err, 0);
    chk("rst_code", o_Err_Code, 0);
    chk("rst_ovr", o_Overrun, 0);
    chk("rst_busy", o_Busy, 0);
    i_Reset = 1'b0;
    tick();

    for (int r = 0; r < 9; r++) run_vec(vecs[r]);

    // Good frame with exact latency and back-to-back delivery.
    dq.push_back({1'b0, 8'h11}); dq.push_back({1'b0, 8'h22}); dq.push_back({1'b1, 8'h33});
    evq.push_back(3'b100);
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    chk("good_ok_pulse", o_Frame_Ok, 1);
    chk("good_valid", o_Cmd_Valid, 1);
    chk("good_b0", o_Cmd_Byte, 8'h11);
    chk("good_last0", o_Cmd_Last, 0);
    tick();
    chk("good_ok_one_cycle", o_Frame_Ok, 0);
    chk("good_b1", o_Cmd_Byte, 8'h22);
    chk("good_last1", o_Cmd_Last, 0);
    tick();
    chk("good_b2", o_Cmd_Byte, 8'h33);
    chk("good_last2", o_Cmd_Last, 1);
    tick();
    chk("good_valid_low", o_Cmd_Valid, 0);
    wait_drain();

    // Timeout fires exactly TMO-1 clocks after the last strobe.
    evq.push_back({1'b0, 2'd3});
    send(8'hAA); send(8'h02); send(8'h10);
    for (int k = 0; k < TMO - 2; k++) tick();
    chk("tmo_not_early", o_Frame_Err, 0);
    tick();
    chk("tmo_err", o_Frame_Err, 1);
    chk("tmo_code", o_Err_Code, 3);
    wait_drain();

    // A strobe on the terminal cycle is accepted instead.
    dq.push_back({1'b0, 8'h10}); dq.push_back({1'b1, 8'h20});
    evq.push_back(3'b100);
    send(8'hAA); send(8'h02); send(8'h10);
    for (int k = 0; k < TMO - 2; k++) tick();
    send(8'h20);
    chk("tmo_byte_wins", o_Frame_Err, 0);
    chk("tmo_still_busy", o_Busy, 1);
    send(8'h32);
    wait_drain();

    // Backpressure with overrun bytes injected during drain.
    i_Cmd_Ready = 1'b0;
    dq.push_back({1'b0, 8'h11}); dq.push_back({1'b0, 8'h22}); dq.push_back({1'b1, 8'h33});
    evq.push_back(3'b100);
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    tick(); tick();
    chk("hold_valid", o_Cmd_Valid, 1);
    chk("hold_byte", o_Cmd_Byte, 8'h11);
    chk("hold_last", o_Cmd_Last, 0);
    send(8'h55);
    chk("ovr_pulse", o_Overrun, 1);
    chk("ovr_hold_byte", o_Cmd_Byte, 8'h11);
    tick();
    chk("ovr_one_cycle", o_Overrun, 0);
    send(8'hAA);
    chk("ovr_sof", o_Overrun, 1);
    chk("ovr_sof_busy", o_Busy, 1);
    tick();
    i_Cmd_Ready = 1'b1;
    wait_drain();

    // Reset mid-payload abandons the frame.
    send(8'hAA); send(8'h04); send(8'h01);
    i_Reset = 1'b1;
    tick();
    chk("mrst_valid", o_Cmd_Valid, 0);
    chk("mrst_ok", o_Frame_Ok, 0);
    chk("mrst_err", o_Frame_Err, 0);
    chk("mrst_code", o_Err_Code, 0);
    chk("mrst_ovr", o_Overrun, 0);
    chk("mrst_busy", o_Busy, 0);
    i_Reset = 1'b0;
    tick();
    run_vec(vecs[4]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
